pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 46 ++++
 tb/tb_pipe_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline hazard signals; master drives stage info, slave returns register enables, bubbles and status.
interface pipe_hazard_ctrl_if;
  logic [2:0]  ID_Rs;
  logic [2:0]  ID_Rd;
  logic        ID_UsesRs;
  logic        ID_UsesRd;
  logic        EX_MemRead;
  logic [2:0]  EX_Rd;
  logic        BranchTaken;
  logic        MEM_Req;
  logic        MEM_Ready;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IDEX_Write;
  logic        EXMEM_Write;
  logic        IFID_Flush;
  logic        IDEX_Bubble;
  logic        MEMWB_Bubble;
  logic [15:0] StallCount;
  logic        MemTimeout;
  modport master (
    output ID_Rs, ID_Rd, ID_UsesRs, ID_UsesRd, EX_MemRead, EX_Rd, BranchTaken, MEM_Req, MEM_Ready,
    input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, StallCount, MemTimeout
  );
  modport slave (
    input  ID_Rs, ID_Rd, ID_UsesRs, ID_UsesRd, EX_MemRead, EX_Rd, BranchTaken, MEM_Req, MEM_Ready,
    output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, StallCount, MemTimeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Mealy hazard controller (mem wait > taken branch > load-use); ports clk, reset, bus (slave: stage info in, enables/bubbles/StallCount/MemTimeout out).
module pipe_hazard_ctrl (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2;
  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_wait;
  logic [15:0] r_stall_cnt;
  logic        r_timeout;
  logic        w_mem;
  logic        w_lu;
  logic        w_hold;
  logic [6:0]  w_ctl;
  // once waiting, only MEM_Ready releases the stall
  assign w_mem = (r_state == MEM_WAIT || bus.MEM_Req) && !bus.MEM_Ready;
  assign w_hold = r_state == MEM_WAIT && w_mem;
  // masked in LU_STALL so each load inserts exactly one bubble
  assign w_lu = r_state != LU_STALL && bus.EX_MemRead && bus.EX_Rd != 3'd0 &&
                ((bus.ID_UsesRs && bus.ID_Rs == bus.EX_Rd) || (bus.ID_UsesRd && bus.ID_Rd == bus.EX_Rd));
  // {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble}
  assign w_ctl = reset           ? 7'b0011111 :
                 w_mem           ? 7'b0000001 :
                 bus.BranchTaken ? 7'b1111110 :
                 w_lu            ? 7'b0010010 : 7'b1111000;
  assign {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.EXMEM_Write,
          bus.IFID_Flush, bus.IDEX_Bubble, bus.MEMWB_Bubble} = w_ctl;
  assign w_next = w_mem ? MEM_WAIT : (!bus.BranchTaken && w_lu) ? LU_STALL : RUN;
  assign bus.StallCount = r_stall_cnt;
  assign bus.MemTimeout = r_timeout;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait      <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wait      <= w_hold ? (r_wait == 8'hFF ? r_wait : r_wait + 8'd1) : 8'd0;
      r_timeout   <= r_timeout | (w_hold && r_wait == 8'hFE);
      if (!w_ctl[6] && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] ctl;
  assign ctl = {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.EXMEM_Write,
                bus.IFID_Flush, bus.IDEX_Bubble, bus.MEMWB_Bubble};
  task automatic idle();
    bus.ID_Rs = 3'd0; bus.ID_Rd = 3'd0; bus.ID_UsesRs = 1'b0; bus.ID_UsesRd = 1'b0;
    bus.EX_MemRead = 1'b0; bus.EX_Rd = 3'd0; bus.BranchTaken = 1'b0;
    bus.MEM_Req = 1'b0; bus.MEM_Ready = 1'b0;
  endtask
  task automatic lu_rs();
    bus.EX_MemRead = 1'b1; bus.EX_Rd = 3'd3; bus.ID_Rs = 3'd3; bus.ID_UsesRs = 1'b1;
  endtask
  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; idle();
    @(negedge clk); reset = 1'b0; #1;
  endtask
  task automatic test_reset();
    idle();
    @(negedge clk); #1;
    checks++; if (ctl !== 7'b0011111) begin errors++; $display("FAIL reset_outputs got %b want %b", ctl, 7'b0011111); end
    @(negedge clk); #1;
    checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL reset_stallcount got %0d want 0", bus.StallCount); end
    checks++; if (bus.MemTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.MemTimeout); end
    reset = 1'b0; #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL idle_defaults got %b want %b", ctl, 7'b1111000); end
  endtask
  task automatic test_load_use();
    @(negedge clk); lu_rs(); #1;
    checks++; if (ctl !== 7'b0010010) begin errors++; $display("FAIL lu_stall got %b want %b", ctl, 7'b0010010); end
    @(negedge clk); #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL lu_single_bubble got %b want %b", ctl, 7'b1111000); end
    checks++; if (bus.StallCount !== 16'd1) begin errors++; $display("FAIL lu_stallcount got %0d want 1", bus.StallCount); end
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_Rd = 3'd5; bus.ID_Rd = 3'd5; bus.ID_UsesRd = 1'b1; bus.ID_Rs = 3'd2; bus.ID_UsesRs = 1'b1; #1;
    checks++; if (ctl !== 7'b0010010) begin errors++; $display("FAIL lu_rd_stall got %b want %b", ctl, 7'b0010010); end
    @(negedge clk); idle();
    bus.EX_MemRead = 1'b1; bus.EX_Rd = 3'd5; bus.ID_Rd = 3'd5; bus.ID_Rs = 3'd5; #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL lu_unused_regs got %b want %b", ctl, 7'b1111000); end
    checks++; if (bus.StallCount !== 16'd2) begin errors++; $display("FAIL lu_rd_stallcount got %0d want 2", bus.StallCount); end
    @(negedge clk); idle(); bus.EX_MemRead = 1'b0; bus.EX_Rd = 3'd3; bus.ID_Rs = 3'd3; bus.ID_UsesRs = 1'b1; #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL lu_not_load got %b want %b", ctl, 7'b1111000); end
  endtask
  task automatic test_r0_guard();
    @(negedge clk); idle(); bus.EX_MemRead = 1'b1; bus.EX_Rd = 3'd0; bus.ID_Rs = 3'd0; bus.ID_UsesRs = 1'b1;
    bus.ID_Rd = 3'd0; bus.ID_UsesRd = 1'b1; #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL r0_guard got %b want %b", ctl, 7'b1111000); end
  endtask
  task automatic test_branch_lu();
    @(negedge clk); idle(); lu_rs(); bus.BranchTaken = 1'b1; #1;
    checks++; if (ctl !== 7'b1111110) begin errors++; $display("FAIL branch_lu got %b want %b", ctl, 7'b1111110); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.StallCount !== 16'd2) begin errors++; $display("FAIL branch_stallcount got %0d want 2", bus.StallCount); end
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL branch_next got %b want %b", ctl, 7'b1111000); end
  endtask
  task automatic test_mem_wait();
    pulse_reset();
    checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL mw_cleared got %0d want 0", bus.StallCount); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.MEM_Req = 1'b1; bus.MEM_Ready = 1'b0; bus.BranchTaken = 1'b1; lu_rs(); #1;
      checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL mw_hold%0d got %b want %b", i, ctl, 7'b0000001); end
    end
    @(negedge clk); bus.MEM_Ready = 1'b1; #1;
    checks++; if (ctl !== 7'b1111110) begin errors++; $display("FAIL mw_release_branch got %b want %b", ctl, 7'b1111110); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL mw_after got %b want %b", ctl, 7'b1111000); end
    checks++; if (bus.StallCount !== 16'd4) begin errors++; $display("FAIL mw_stallcount got %0d want 4", bus.StallCount); end
    @(negedge clk); bus.MEM_Req = 1'b1; bus.MEM_Ready = 1'b0; lu_rs(); #1;
    @(negedge clk); bus.MEM_Ready = 1'b1; #1;
    checks++; if (ctl !== 7'b0010010) begin errors++; $display("FAIL mw_release_lu got %b want %b", ctl, 7'b0010010); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.StallCount !== 16'd6) begin errors++; $display("FAIL mw_lu_stallcount got %0d want 6", bus.StallCount); end
  endtask
  task automatic test_timeout();
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); bus.MEM_Req = 1'b1; bus.MEM_Ready = 1'b0; #1;
      if (i == 150) begin
        checks++; if (bus.MemTimeout !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", bus.MemTimeout); end
      end
    end
    checks++; if (bus.MemTimeout !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", bus.MemTimeout); end
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL to_still_wait got %b want %b", ctl, 7'b0000001); end
    @(negedge clk); bus.MEM_Ready = 1'b1; #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL to_release got %b want %b", ctl, 7'b1111000); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); #1;
      checks++; if (bus.MemTimeout !== 1'b1) begin errors++; $display("FAIL to_sticky%0d got %b want 1", i, bus.MemTimeout); end
    end
  endtask
  task automatic test_reset_in_state();
    @(negedge clk); idle(); bus.MEM_Req = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL rs_in_wait got %b want %b", ctl, 7'b0000001); end
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; idle(); #1;
    checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL rs_stallcount got %0d want 0", bus.StallCount); end
    checks++; if (bus.MemTimeout !== 1'b0) begin errors++; $display("FAIL rs_timeout got %b want 0", bus.MemTimeout); end
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL rs_defaults got %b want %b", ctl, 7'b1111000); end
    @(negedge clk); lu_rs(); #1;
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (ctl !== 7'b0010010) begin errors++; $display("FAIL rs_lu_unmasked got %b want %b", ctl, 7'b0010010); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL rs_no_residual got %b want %b", ctl, 7'b1111000); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_r0_guard();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_in_state();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
